// File: rtl/rr_decode_arbiter.sv
// Four-way round-robin arbiter driving a shared 2-to-4 decoder.
// The owner is published both as a binary select (gnt_id_o) and as its
// registered one-hot decode (gnt_o). A grant ends when the owner asserts
// done, drops its request, or reaches the hold limit. An idle cycle
// always separates two grants.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; arbitrate req_i from ptr_q on the next edge
// GRANT | gnt_id_q owns the resource; count hold cycles, watch exits
module rr_decode_arbiter #(
   // Longest grant in cycles; legal range 2..15.
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [3:0] req_i,
   input  logic       done_i,
   output logic [3:0] gnt_o,
   output logic [1:0] gnt_id_o,
   output logic       gnt_valid_o,
   output logic       timeout_o
);

   localparam logic       IDLE      = 1'b0;
   localparam logic       GRANT     = 1'b1;
   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   logic       state_q,   state_d;
   logic [1:0] ptr_q,     ptr_d;
   logic [1:0] gnt_id_q,  gnt_id_d;
   logic [3:0] gnt_q,     gnt_d;
   logic [3:0] hold_q,    hold_d;
   logic       timeout_q, timeout_d;

   logic [1:0] pick_id;
   logic [1:0] cand_id;
   logic       owner_req;
   logic       hold_limit;
   logic       grant_exit;

   // Rotating priority search: walk from ptr_q+3 down to ptr_q so the
   // closest set request (lowest offset from ptr_q) is the last writer.
   always_comb begin
      pick_id = ptr_q;
      cand_id = ptr_q;
      for (int i = 3; i >= 0; i--) begin
         cand_id = ptr_q + 2'(i);
         if (req_i[cand_id]) begin
            pick_id = cand_id;
         end
      end
   end

   assign owner_req  = req_i[gnt_id_q];
   assign hold_limit = (hold_q == HOLD_LAST);
   assign grant_exit = done_i | ~owner_req | hold_limit;

   // Next-state logic for the two-state grant FSM and its side registers.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_id_d  = gnt_id_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_i != 4'b0000) begin
               state_d  = GRANT;
               gnt_id_d = pick_id;
               hold_d   = 4'd0;
            end
         end
         GRANT: begin
            if (grant_exit) begin
               state_d   = IDLE;
               ptr_d     = gnt_id_q + 2'd1;
               hold_d    = 4'd0;
               // Flag only limit-forced exits; a voluntary release wins.
               timeout_d = hold_limit & ~done_i & owner_req;
            end else if (hold_q != 4'hF) begin
               hold_d = hold_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      gnt_d = (state_d == GRANT) ? (4'b0001 << gnt_id_d) : 4'b0000;
   end

   // State, pointer, owner and decoded grant registers; reset clears all.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         ptr_q     <= 2'd0;
         gnt_id_q  <= 2'd0;
         gnt_q     <= 4'b0000;
         hold_q    <= 4'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_id_q  <= gnt_id_d;
         gnt_q     <= gnt_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_id_o    = gnt_id_q;
   assign gnt_valid_o = state_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter (MAX_HOLD = 8). Inputs change just
// after a falling edge; outputs are sampled on the following falling edge.
module tb_rr_decode_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int n_vec = 0;
   int n_err = 0;

   rr_decode_arbiter #(.MAX_HOLD(8)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .req_i       (req),
      .done_i      (done),
      .gnt_o       (gnt),
      .gnt_id_o    (gnt_id),
      .gnt_valid_o (gnt_valid),
      .timeout_o   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Full output check against hand-computed values.
   task automatic chk(input string tag, input logic [3:0] eg, input logic ev,
                      input logic [1:0] eid, input logic eto);
      logic [7:0] obs;
      logic [7:0] exp;
      obs = {gnt, gnt_valid, gnt_id, timeout};
      exp = {eg, ev, eid, eto};
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed gnt=%b valid=%b id=%0d to=%b, expected gnt=%b valid=%b id=%0d to=%b",
                tag, gnt, gnt_valid, gnt_id, timeout, eg, ev, eid, eto);
      end
   endtask

   // One clock, then the every-cycle decode / one-hot check.
   task automatic tick();
      logic [3:0] dec;
      @(posedge clk);
      @(negedge clk);
      dec = 4'b0000;
      if (gnt_valid === 1'b1) begin
         case (gnt_id)
            2'd0: dec = 4'b0001;
            2'd1: dec = 4'b0010;
            2'd2: dec = 4'b0100;
            2'd3: dec = 4'b1000;
            default: dec = 4'bxxxx;
         endcase
      end
      n_vec++;
      assert ((gnt === dec) && ($countones(gnt) <= 1)) else begin
         n_err++;
         $error("FAIL decode_inv: observed gnt=%b (valid=%b id=%0d), expected gnt=%b",
                gnt, gnt_valid, gnt_id, dec);
      end
   endtask

   // From IDLE: grant to exp_id for three cycles, done on cycle 3, then idle.
   task automatic grant_done(input string tag, input logic [1:0] eid, input logic [3:0] eg);
      tick(); chk({tag, "_c1"}, eg, 1'b1, eid, 1'b0);
      tick(); chk({tag, "_c2"}, eg, 1'b1, eid, 1'b0);
      tick(); chk({tag, "_c3"}, eg, 1'b1, eid, 1'b0);
      done = 1'b1;
      tick(); chk({tag, "_gap"}, 4'b0000, 1'b0, eid, 1'b0);
      done = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1;
      req   = 4'b0000;
      done  = 1'b0;
      #1 rst_n = 1'b0;
      #2 chk("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b0101;

      // Alternating 0 and 2 with a dead cycle between grants.
      grant_done("r0101_a", 2'd0, 4'b0001);
      grant_done("r0101_b", 2'd2, 4'b0100);
      grant_done("r0101_c", 2'd0, 4'b0001);

      // Reset in IDLE, then full rotation with wrap 3 -> 0.
      rst_n = 1'b0;
      #1 chk("reset2", 4'b0000, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b1111;
      grant_done("r1111_0", 2'd0, 4'b0001);
      grant_done("r1111_1", 2'd1, 4'b0010);
      grant_done("r1111_2", 2'd2, 4'b0100);
      grant_done("r1111_3", 2'd3, 4'b1000);
      grant_done("r1111_w", 2'd0, 4'b0001);

      // Hold limit: exactly 8 cycles, timeout on the exit edge, re-grant.
      req = 4'b0010;
      for (int i = 0; i < 8; i++) begin
         tick(); chk("hold8", 4'b0010, 1'b1, 2'd1, 1'b0);
      end
      tick(); chk("hold8_timeout", 4'b0000, 1'b0, 2'd1, 1'b1);
      tick(); chk("hold8_regrant", 4'b0010, 1'b1, 2'd1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         tick(); chk("hold8_b", 4'b0010, 1'b1, 2'd1, 1'b0);
      end
      // done coincides with the hold limit: normal exit, no timeout.
      done = 1'b1;
      tick(); chk("done_at_limit", 4'b0000, 1'b0, 2'd1, 1'b0);
      done = 1'b0;

      // Owner 2 drops its request; pending 1001 goes to 3 (ptr = 3).
      req = 4'b0100;
      tick(); chk("own2_c1", 4'b0100, 1'b1, 2'd2, 1'b0);
      tick(); chk("own2_c2", 4'b0100, 1'b1, 2'd2, 1'b0);
      req = 4'b1001;
      tick(); chk("own2_drop", 4'b0000, 1'b0, 2'd2, 1'b0);
      tick(); chk("r1001_grant", 4'b1000, 1'b1, 2'd3, 1'b0);
      done = 1'b1;
      tick(); chk("r1001_done", 4'b0000, 1'b0, 2'd3, 1'b0);

      // done in IDLE has no effect; no requests keeps everything idle.
      req = 4'b0000;
      tick(); chk("idle_done", 4'b0000, 1'b0, 2'd3, 1'b0);
      req = 4'b0010;
      tick(); chk("grant1", 4'b0010, 1'b1, 2'd1, 1'b0);
      done = 1'b0;
      tick(); chk("grant1_hold", 4'b0010, 1'b1, 2'd1, 1'b0);

      // Asynchronous reset mid-grant, then ptr restarts at 0.
      #2 rst_n = 1'b0;
      #1 chk("async_reset", 4'b0000, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b1110;
      tick(); chk("post_reset", 4'b0010, 1'b1, 2'd1, 1'b0);
      done = 1'b1;
      tick(); chk("post_reset_done", 4'b0000, 1'b0, 2'd1, 1'b0);
      done = 1'b0;
      req  = 4'b0000;
      tick(); chk("final_idle", 4'b0000, 1'b0, 2'd1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
